// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared types and defaults for the LC-3 memory arbiter
package lc3_mem_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    F_ACC,
    D_ACC,
    D_PTR,
    D_GAP,
    D_IND
  } arb_state_t;

  typedef enum logic {
    REQ_F,
    REQ_D
  } req_id_t;

  // Only F_ACC belongs to the fetch side; every other busy state serves D.
  function automatic req_id_t owner_of(input arb_state_t s);
    return (s == F_ACC) ? REQ_F : REQ_D;
  endfunction

endpackage

// File: rtl/lc3_mem_timer.sv
// rtl/lc3_mem_timer.sv - per-access timeout counter (load/count/expire)
module lc3_mem_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT + 1);

  // Holds the number of strobe cycles elapsed including the current one.
  logic [TW-1:0] timer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (load) begin
      timer <= TW'(1);
    end else if (count) begin
      timer <= timer + TW'(1);
    end else begin
      timer <= '0;
    end
  end

  assign expire = (timer == TW'(TIMEOUT));

endmodule

// File: rtl/lc3_mem_arbiter.sv
// rtl/lc3_mem_arbiter.sv - shares the LC-3 memory port between fetch and data requesters
module lc3_mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int TIMEOUT      = 64,
  parameter int MAX_D_STREAK = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_done,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_ind,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          f_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_complete,
  output logic          busy
);

  localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);

  arb_state_t    state;
  logic [SW-1:0] streak;
  logic [AW-1:0] ptr;

  logic    in_access;
  logic    arb_ok;
  logic    expire;
  logic    t_load;
  logic    t_count;
  req_id_t winner;

  assign in_access = (state == F_ACC) || (state == D_ACC) ||
                     (state == D_PTR) || (state == D_IND);

  // No arbitration while a done pulse is visible: the finishing requester
  // has not yet had a chance to drop its request.
  assign arb_ok = (state == IDLE) && !f_done && !d_done && (f_req || d_req);

  always_comb begin
    winner = REQ_D;
    if (f_req && (!d_req || streak == SW'(MAX_D_STREAK))) begin
      winner = REQ_F;
    end
  end

  assign t_load  = arb_ok || (state == D_GAP);
  assign t_count = in_access && !mem_complete && !expire;

  lc3_mem_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (t_load),
    .count (t_count),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      streak    <= '0;
      ptr       <= '0;
      f_gnt     <= 1'b0;
      f_done    <= 1'b0;
      f_err     <= 1'b0;
      f_rdata   <= '0;
      d_gnt     <= 1'b0;
      d_done    <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      f_gnt  <= 1'b0;
      d_gnt  <= 1'b0;
      f_done <= 1'b0;
      d_done <= 1'b0;
      f_err  <= 1'b0;
      d_err  <= 1'b0;

      if (in_access && !mem_complete && expire) begin
        // Timeout aborts the whole operation, including a pending D_IND.
        mem_en <= 1'b0;
        busy   <= 1'b0;
        state  <= IDLE;
        if (owner_of(state) == REQ_F) begin
          f_done  <= 1'b1;
          f_err   <= 1'b1;
          f_rdata <= '0;
        end else begin
          d_done  <= 1'b1;
          d_err   <= 1'b1;
          d_rdata <= '0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (arb_ok) begin
              mem_en <= 1'b1;
              busy   <= 1'b1;
              if (winner == REQ_F) begin
                f_gnt    <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= f_addr;
                streak   <= '0;
                state    <= F_ACC;
              end else begin
                d_gnt    <= 1'b1;
                mem_addr <= d_addr;
                if (f_req && streak != SW'(MAX_D_STREAK)) begin
                  streak <= streak + SW'(1);
                end
                if (d_ind) begin
                  mem_we <= 1'b0;
                  state  <= D_PTR;
                end else begin
                  mem_we    <= d_we;
                  mem_wdata <= d_wdata;
                  state     <= D_ACC;
                end
              end
            end
          end

          F_ACC, D_ACC, D_IND: begin
            if (mem_complete) begin
              mem_en <= 1'b0;
              busy   <= 1'b0;
              state  <= IDLE;
              if (state == F_ACC) begin
                f_done  <= 1'b1;
                f_rdata <= mem_rdata;
              end else begin
                d_done <= 1'b1;
                if (!mem_we) begin
                  d_rdata <= mem_rdata;
                end
              end
            end
          end

          D_PTR: begin
            if (mem_complete) begin
              ptr    <= mem_rdata[AW-1:0];
              mem_en <= 1'b0;
              state  <= D_GAP;
            end
          end

          D_GAP: begin
            mem_en    <= 1'b1;
            mem_addr  <= ptr;
            mem_we    <= d_we;
            mem_wdata <= d_wdata;
            state     <= D_IND;
          end

          default: begin
            mem_en <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb/tb_lc3_mem_arbiter.sv - scoreboard bench for lc3_mem_arbiter
module tb_lc3_mem_arbiter;

  typedef struct {
    logic        is_d;
    logic [15:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_req = 1'b0;
  logic [15:0] f_addr = '0;
  logic        f_gnt, f_done, f_err;
  logic [15:0] f_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic        d_ind = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_gnt, d_done, d_err;
  logic [15:0] d_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_complete = 1'b0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic gnt_q[$];
  exp_t done_q[$];

  lc3_mem_arbiter #(
    .AW(16), .DW(16), .TIMEOUT(4), .MAX_D_STREAK(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_done(f_done), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_ind(d_ind), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err), .f_err(f_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_complete(mem_complete), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a grant or done pulse appears.
  always @(negedge clk) begin
    logic g;
    exp_t e;
    if (f_gnt || d_gnt) begin
      if (gnt_q.size() == 0) begin
        chk("unexpected gnt", 32'({f_gnt, d_gnt}), 32'd0);
      end else begin
        g = gnt_q.pop_front();
        chk("gnt owner", 32'({f_gnt, d_gnt}), g ? 32'd1 : 32'd2);
      end
    end
    if (f_done || d_done) begin
      if (done_q.size() == 0) begin
        chk("unexpected done", 32'({f_done, d_done}), 32'd0);
      end else begin
        e = done_q.pop_front();
        chk("done owner", 32'({f_done, d_done}), e.is_d ? 32'd1 : 32'd2);
        chk("done rdata", 32'(e.is_d ? d_rdata : f_rdata), 32'(e.data));
        chk("done err", 32'(e.is_d ? d_err : f_err), 32'(e.err));
      end
    end
  end

  // Act as memory for one access: wait for the strobe, check it, answer after lat cycles.
  task automatic serve(input string nm, input logic [15:0] ea, input logic ew,
                       input logic [15:0] ewd, input int lat, input logic [15:0] rd,
                       output int waited);
    waited = 0;
    while (!mem_en && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!mem_en) begin
      chk({nm, " mem_en timeout"}, 32'(mem_en), 32'd1);
      return;
    end
    chk({nm, " addr"}, 32'(mem_addr), 32'(ea));
    chk({nm, " we"}, 32'(mem_we), 32'(ew));
    if (ew) chk({nm, " wdata"}, 32'(mem_wdata), 32'(ewd));
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      chk({nm, " held"}, 32'({mem_en, mem_we}), 32'({1'b1, ew}));
    end
    mem_complete = 1'b1;
    mem_rdata    = rd;
    @(negedge clk);
    mem_complete = 1'b0;
    mem_rdata    = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int cnt;

    @(negedge clk);
    chk("reset outs", 32'({mem_en, mem_we, f_gnt, f_done, f_err, d_gnt, d_done, d_err, busy}), 32'd0);
    chk("reset data", 32'(mem_addr | mem_wdata | f_rdata | d_rdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fetch alone, complete on the 3rd strobe cycle.
    f_req = 1'b1; f_addr = 16'h3000;
    gnt_q.push_back(1'b0);
    done_q.push_back('{1'b0, 16'h1261, 1'b0});
    serve("fetch", 16'h3000, 1'b0, 16'h0, 3, 16'h1261, w);
    chk("fetch grant latency", 32'(w), 32'd1);
    chk("fetch done visible", 32'(f_done), 32'd1);
    f_req = 1'b0;
    repeat (2) @(negedge clk);

    // Both requesters held: D, D, then F forced by the streak limit.
    f_req = 1'b1; f_addr = 16'h3001;
    d_req = 1'b1; d_addr = 16'h4000; d_we = 1'b0; d_ind = 1'b0;
    gnt_q.push_back(1'b1); gnt_q.push_back(1'b1); gnt_q.push_back(1'b0);
    done_q.push_back('{1'b1, 16'h1111, 1'b0});
    done_q.push_back('{1'b1, 16'h2222, 1'b0});
    done_q.push_back('{1'b0, 16'h3333, 1'b0});
    serve("arb d1", 16'h4000, 1'b0, 16'h0, 1, 16'h1111, w);
    serve("arb d2", 16'h4000, 1'b0, 16'h0, 1, 16'h2222, w);
    serve("arb f", 16'h3001, 1'b0, 16'h0, 1, 16'h3333, w);
    chk("streak cleared", 32'(dut.streak), 32'd0);
    f_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);

    // LDI: pointer at x5000 -> x6000 -> x00AB.
    d_req = 1'b1; d_ind = 1'b1; d_we = 1'b0; d_addr = 16'h5000;
    gnt_q.push_back(1'b1);
    done_q.push_back('{1'b1, 16'h00AB, 1'b0});
    serve("ldi ptr", 16'h5000, 1'b0, 16'h0, 1, 16'h6000, w);
    chk("ldi gap mem_en", 32'(mem_en), 32'd0);
    serve("ldi tgt", 16'h6000, 1'b0, 16'h0, 2, 16'h00AB, w);
    chk("ldi gap length", 32'(w), 32'd1);
    d_req = 1'b0;
    repeat (2) @(negedge clk);

    // STI: pointer at x5002 -> x7000, write xBEEF, d_rdata keeps x00AB.
    d_req = 1'b1; d_ind = 1'b1; d_we = 1'b1; d_addr = 16'h5002; d_wdata = 16'hBEEF;
    gnt_q.push_back(1'b1);
    done_q.push_back('{1'b1, 16'h00AB, 1'b0});
    serve("sti ptr", 16'h5002, 1'b0, 16'h0, 1, 16'h7000, w);
    serve("sti tgt", 16'h7000, 1'b1, 16'hBEEF, 1, 16'hDEAD, w);
    d_req = 1'b0; d_ind = 1'b0; d_we = 1'b0;
    repeat (2) @(negedge clk);

    // Timeout: no completion; strobe lasts exactly TIMEOUT cycles.
    d_req = 1'b1; d_addr = 16'h4100;
    gnt_q.push_back(1'b1);
    done_q.push_back('{1'b1, 16'h0000, 1'b1});
    w = 0;
    while (!mem_en && w < 20) begin @(negedge clk); w++; end
    cnt = 0;
    while (mem_en && cnt < 20) begin cnt++; @(negedge clk); end
    chk("timeout strobe cycles", 32'(cnt), 32'd4);
    d_req = 1'b0;
    @(negedge clk);
    mem_complete = 1'b1;
    @(negedge clk);
    mem_complete = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle after late complete", 32'({mem_en, busy}), 32'd0);

    // Async reset during D_IND.
    d_req = 1'b1; d_ind = 1'b1; d_addr = 16'h5004;
    gnt_q.push_back(1'b1);
    serve("rst ptr", 16'h5004, 1'b0, 16'h0, 1, 16'h8000, w);
    w = 0;
    while (!mem_en && w < 20) begin @(negedge clk); w++; end
    chk("rst in D_IND addr", 32'(mem_addr), 32'h8000);
    #2 rst_n = 1'b0;
    #1;
    chk("rst outs", 32'({mem_en, mem_we, f_gnt, f_done, f_err, d_gnt, d_done, d_err, busy}), 32'd0);
    chk("rst data", 32'(mem_addr | mem_wdata | f_rdata | d_rdata), 32'd0);
    d_req = 1'b0; d_ind = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Fetch after reset is serviced normally.
    f_req = 1'b1; f_addr = 16'h3010;
    gnt_q.push_back(1'b0);
    done_q.push_back('{1'b0, 16'hABCD, 1'b0});
    serve("post rst fetch", 16'h3010, 1'b0, 16'h0, 1, 16'hABCD, w);
    f_req = 1'b0;
    repeat (3) @(negedge clk);

    chk("gnt queue drained", 32'(gnt_q.size()), 32'd0);
    chk("done queue drained", 32'(done_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
